// File: rtl/div_signed_seq_pkg.sv
// ---------------------------------------------------------------------------
// Module : div_signed_seq_pkg
// Brief  : Shared FSM encodings and sizing helper for div_signed_seq.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package div_signed_seq_pkg;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_PREP = 2'd1;
    localparam logic [1:0] C_ST_ITER = 2'd2;
    localparam logic [1:0] C_ST_FIX  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_PREP = C_ST_PREP,
        ST_ITER = C_ST_ITER,
        ST_FIX  = C_ST_FIX
    } state_t;

    // Counter must hold the full iteration count N+M.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_signed_seq_add_sub.sv
// ---------------------------------------------------------------------------
// Module : Nbit_add_sub
// Brief  : N-bit adder/subtractor; i_k=1 gives i_a - i_b, i_k=0 gives i_a + i_b.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module Nbit_add_sub #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_k,
    output logic [N-1:0] o_s
);

    logic [N-1:0] w_b_inv;
    logic [N-1:0] w_cin;

    assign w_b_inv = i_b ^ {N{i_k}};
    assign w_cin   = {{(N-1){1'b0}}, i_k};
    assign o_s     = i_a + w_b_inv + w_cin;

endmodule

`default_nettype wire

// File: rtl/div_signed_seq.sv
// ---------------------------------------------------------------------------
// Module : div_signed_seq
// Brief  : Sequential truncating signed divider, one quotient bit per cycle.
//          Optional macro DIV_SIGNED_OUT_REG_EN adds an output register stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module div_signed_seq
    import div_signed_seq_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N+M-1:0]   Y,
    input  logic [M-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [N+M-1:0]   Q,
    output logic [M-1:0]     R,
    output logic             div_zero,
    output logic             ovf
);

    localparam int c_width = N + M;
    localparam int c_cnt_w = cnt_width(c_width);
    localparam logic [c_width-1:0] c_y_min = {1'b1, {(c_width-1){1'b0}}};

    state_t r_state;
    state_t w_next;

    logic [c_width-1:0] r_y;
    logic [c_width-1:0] r_dvd;
    logic [M-1:0]       r_b;
    logic [M-1:0]       r_dsr;
    logic [M-1:0]       r_prem;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sy;
    logic               r_sb;
    logic               r_dz;
    logic               r_ov;

    logic [c_width-1:0] r_q;
    logic [M-1:0]       r_r;
    logic               r_done;
    logic               r_div_zero;
    logic               r_ovf;

    logic               w_busy;
    logic               w_accept;
    logic               w_b_zero;
    logic               w_ovf_case;
    logic [M:0]         w_trial_a;
    logic [M:0]         w_trial_b;
    logic [M:0]         w_diff;
    logic               w_ge;

    assign w_accept   = start && !w_busy && (r_state == ST_IDLE);
    assign w_b_zero   = (r_b == '0);
    assign w_ovf_case = (r_y == c_y_min) && (r_b == '1);

    // Trial subtraction: {prem, next dividend bit} - |B|; sign bit decides q.
    assign w_trial_a = {r_prem, r_dvd[c_width-1]};
    assign w_trial_b = {1'b0, r_dsr};
    assign w_ge      = ~w_diff[M];

    Nbit_add_sub #(
        .N (M + 1)
    ) u_trial_sub (
        .i_a (w_trial_a),
        .i_b (w_trial_b),
        .i_k (1'b1),
        .o_s (w_diff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_PREP;
            ST_PREP: w_next = (w_b_zero || w_ovf_case) ? ST_FIX : ST_ITER;
            ST_ITER: if (r_cnt == c_cnt_w'(1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y        <= '0;
            r_b        <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_prem     <= '0;
            r_cnt      <= '0;
            r_sy       <= 1'b0;
            r_sb       <= 1'b0;
            r_dz       <= 1'b0;
            r_ov       <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_y        <= Y;
                        r_b        <= B;
                        r_div_zero <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_dvd  <= r_y[c_width-1] ? -r_y : r_y;
                    r_dsr  <= r_b[M-1] ? -r_b : r_b;
                    r_sy   <= r_y[c_width-1];
                    r_sb   <= r_b[M-1];
                    r_prem <= '0;
                    r_cnt  <= c_cnt_w'(c_width);
                    r_dz   <= w_b_zero;
                    r_ov   <= w_ovf_case;
                end
                ST_ITER: begin
                    // Dividend register doubles as the quotient shift register.
                    r_prem <= w_ge ? w_diff[M-1:0] : w_trial_a[M-1:0];
                    r_dvd  <= {r_dvd[c_width-2:0], w_ge};
                    r_cnt  <= r_cnt - 1'b1;
                end
                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_q        <= '1;
                        r_r        <= '0;
                        r_div_zero <= 1'b1;
                    end else if (r_ov) begin
                        r_q   <= r_y;
                        r_r   <= '0;
                        r_ovf <= 1'b1;
                    end else begin
                        r_q <= (r_sy ^ r_sb) ? -r_dvd : r_dvd;
                        r_r <= r_sy ? -r_prem : r_prem;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_SIGNED_OUT_REG_EN
    logic [c_width-1:0] r_q_o;
    logic [M-1:0]       r_r_o;
    logic               r_done_o;
    logic               r_div_zero_o;
    logic               r_ovf_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_o        <= '0;
            r_r_o        <= '0;
            r_done_o     <= 1'b0;
            r_div_zero_o <= 1'b0;
            r_ovf_o      <= 1'b0;
        end else begin
            r_q_o        <= r_q;
            r_r_o        <= r_r;
            r_done_o     <= r_done;
            r_div_zero_o <= r_div_zero;
            r_ovf_o      <= r_ovf;
        end
    end

    // r_done marks the cycle the result sits in the output stage.
    assign w_busy   = (r_state != ST_IDLE) || r_done;
    assign done     = r_done_o;
    assign Q        = r_q_o;
    assign R        = r_r_o;
    assign div_zero = r_div_zero_o;
    assign ovf      = r_ovf_o;
`else
    assign w_busy   = (r_state == ST_PREP) || (r_state == ST_ITER);
    assign done     = r_done;
    assign Q        = r_q;
    assign R        = r_r;
    assign div_zero = r_div_zero;
    assign ovf      = r_ovf;
`endif

    assign busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_div_signed_seq.sv
// ---------------------------------------------------------------------------
// Module : tb_div_signed_seq
// Brief  : Self-checking bench for div_signed_seq with N=4, M=4.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_signed_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] Y;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [3:0] R;
    logic       div_zero;
    logic       ovf;

    always #5 clk = ~clk;

    div_signed_seq #(
        .N (4),
        .M (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Y        (Y),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    typedef struct {
        logic [7:0] y;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[16];
    vec_t m_e;
    int   checks   = 0;
    int   failures = 0;
    int   m_qa, m_ra, m_ba, m_ya;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [7:0] y, input logic [3:0] b);
        vec_t v;
        int   yi, bi, qi, ri;
        v.y = y;
        v.b = b;
        v.dz = 1'b0;
        v.ov = 1'b0;
        yi = int'($signed(y));
        bi = int'($signed(b));
        if (bi == 0) begin
            v.q = 8'hFF; v.r = 4'h0; v.dz = 1'b1;
        end else if (yi == -128 && bi == -1) begin
            v.q = 8'h80; v.r = 4'h0; v.ov = 1'b1;
        end else begin
            qi = yi / bi;
            ri = yi % bi;
            v.q = qi[7:0];
            v.r = ri[3:0];
        end
        return v;
    endfunction

    // Scoreboard: every done pops the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("Q", 32'(Q), 32'(m_e.q));
                check("R", 32'(R), 32'(m_e.r));
                check("div_zero", 32'(div_zero), 32'(m_e.dz));
                check("ovf", 32'(ovf), 32'(m_e.ov));
                if (!m_e.dz && !m_e.ov) begin
                    m_qa = int'($signed(Q));
                    m_ra = int'($signed(R));
                    m_ba = int'($signed(m_e.b));
                    m_ya = int'($signed(m_e.y));
                    check("identity_QB_plus_R", 32'(m_qa * m_ba + m_ra), 32'(m_ya));
                    check("rem_magnitude",
                          {31'd0, ((m_ra < 0 ? -m_ra : m_ra) < (m_ba < 0 ? -m_ba : m_ba))}, 32'd1);
                end
            end
        end
    end

    task automatic issue(input vec_t v);
        Y     = v.y;
        B     = v.b;
        start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy && !done) bc++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, bc, nd;
        logic [7:0] ry;
        logic [3:0] rb;

        rst = 1'b1; start = 1'b0; Y = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_Q", 32'(Q), 32'd0);
        check("reset_R", 32'(R), 32'd0);
        check("reset_div_zero", 32'(div_zero), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        tbl[0]  = '{8'd100, 4'd7,  8'h0E, 4'h2, 1'b0, 1'b0};
        tbl[1]  = '{8'h9C,  4'd7,  8'hF2, 4'hE, 1'b0, 1'b0};
        tbl[2]  = '{8'd100, 4'h9,  8'hF2, 4'h2, 1'b0, 1'b0};
        tbl[3]  = '{8'h9C,  4'h9,  8'h0E, 4'hE, 1'b0, 1'b0};
        tbl[4]  = '{8'd37,  4'h0,  8'hFF, 4'h0, 1'b1, 1'b0};
        tbl[5]  = '{8'h80,  4'hF,  8'h80, 4'h0, 1'b0, 1'b1};
        tbl[6]  = '{8'h7F,  4'h1,  8'h7F, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{8'h80,  4'h1,  8'h80, 4'h0, 1'b0, 1'b0};
        tbl[8]  = '{8'h80,  4'h7,  8'hEE, 4'hE, 1'b0, 1'b0};
        tbl[9]  = '{8'h05,  4'h8,  8'h00, 4'h5, 1'b0, 1'b0};
        tbl[10] = '{8'hF9,  4'h8,  8'h00, 4'h9, 1'b0, 1'b0};
        tbl[11] = '{8'h7F,  4'h8,  8'hF1, 4'h7, 1'b0, 1'b0};
        tbl[12] = '{8'h80,  4'h8,  8'h10, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{8'h00,  4'h5,  8'h00, 4'h0, 1'b0, 1'b0};
        tbl[14] = '{8'hFF,  4'h3,  8'h00, 4'hF, 1'b0, 1'b0};
        tbl[15] = '{8'h00,  4'h0,  8'hFF, 4'h0, 1'b1, 1'b0};

        // Each op after the first is issued in the previous done cycle.
        for (int i = 0; i < 16; i++) begin
            issue(tbl[i]);
            if (i > 0 && tbl[i-1].ov) check("ovf_clear_on_accept", 32'(ovf), 32'd0);
            if (i > 0 && tbl[i-1].dz) check("dz_clear_on_accept", 32'(div_zero), 32'd0);
            wait_done(lat, bc);
            check("latency", 32'(lat), (tbl[i].dz || tbl[i].ov) ? 32'd2 : 32'd10);
            if (!tbl[i].dz && !tbl[i].ov) check("busy_cycles", 32'(bc), 32'd9);
        end

        // start pulsed while busy must be ignored
        repeat (2) @(posedge clk);
        #1;
        issue(model(8'd100, 4'd7));
        repeat (2) @(posedge clk);
        #1;
        Y = 8'd1; B = 4'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("busy_ignore_latency", 32'(lat), 32'd7);
        count_done(12, nd);
        check("busy_ignore_no_extra_done", 32'(nd), 32'd0);

        // reset during ITER aborts without a done
        Y = 8'd100; B = 4'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_Q", 32'(Q), 32'd0);
        check("abort_R", 32'(R), 32'd0);
        check("abort_flags", {30'd0, div_zero, ovf}, 32'd0);
        count_done(14, nd);
        check("abort_no_done", 32'(nd), 32'd0);
        issue(model(8'h9C, 4'd7));
        wait_done(lat, bc);
        check("after_abort_latency", 32'(lat), 32'd10);

        // random operands, issued back-to-back on each done cycle
        for (int k = 0; k < 20; k++) begin
            ry = 8'($urandom);
            rb = 4'($urandom);
            while (rb == 4'h0 || (ry == 8'h80 && rb == 4'hF)) rb = 4'($urandom);
            issue(model(ry, rb));
            wait_done(lat, bc);
            check("rand_latency", 32'(lat), 32'd10);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
